// File: rtl/dma_block_mover.sv
// Single-channel block-copy bus master: requests the memory bus, then moves SZ
// words or bytes from source to destination as read/write cycle pairs.
module dma_block_mover #(
    parameter int unsigned BURST_LEN = 0
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] SRC,
    input  logic [15:0] DST,
    input  logic [15:0] SZ,
    input  logic        BWmode,
    input  logic        SRCINC,
    input  logic        DSTINC,
    input  logic        busGrant,
    input  logic [15:0] MDBread,
    output logic        busReq,
    output logic [15:0] MAB,
    output logic [15:0] MDBwrite,
    output logic        MW,
    output logic        BW,
    output logic        busy,
    output logic        done,
    output logic [15:0] remaining
);

    localparam int unsigned AW = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        RELEASE,
        DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] data;
    logic [AW-1:0] burst_cnt;
    logic [AW-1:0] step;
    logic          mode;
    logic          src_inc;
    logic          dst_inc;
    logic          owner;
    logic          last_elem;
    logic          burst_full;

    assign owner      = ((state == READ) || (state == WRITE)) && busGrant;
    assign step       = mode ? AW'(1) : AW'(2);
    assign last_elem  = (remaining == AW'(1));
    assign burst_full = (BURST_LEN != 0) && ((burst_cnt + AW'(1)) == AW'(BURST_LEN));

    // Next-state logic; abort overrides everything outside IDLE
    always_comb begin
        next_state = state;
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = (SZ != AW'(0)) ? REQ : DONE;
                REQ:     if (busGrant) next_state = READ;
                READ:    if (busGrant) next_state = WRITE;
                WRITE: begin
                    if (busGrant) begin
                        if (last_elem)       next_state = DONE;
                        else if (burst_full) next_state = RELEASE;
                        else                 next_state = READ;
                    end
                end
                RELEASE: next_state = REQ;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered status outputs, aligned with the state they describe
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            busReq <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busReq <= next_state inside {REQ, READ, WRITE};
            busy   <= (next_state != IDLE);
            done   <= (state == DONE) && !abort;
        end
    end

    // Datapath: config latch, read capture, and per-element bookkeeping
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            src_addr  <= AW'(0);
            dst_addr  <= AW'(0);
            data      <= AW'(0);
            burst_cnt <= AW'(0);
            remaining <= AW'(0);
            mode      <= 1'b0;
            src_inc   <= 1'b0;
            dst_inc   <= 1'b0;
        end else if ((state == IDLE) && start) begin
            src_addr  <= SRC;
            dst_addr  <= DST;
            remaining <= SZ;
            burst_cnt <= AW'(0);
            mode      <= BWmode;
            src_inc   <= SRCINC;
            dst_inc   <= DSTINC;
        end else if (!abort) begin
            if ((state == READ) && busGrant) begin
                data <= mode ? {8'h00, MDBread[7:0]} : MDBread;
            end
            if ((state == WRITE) && busGrant) begin
                remaining <= remaining - AW'(1);
                burst_cnt <= burst_full ? AW'(0) : burst_cnt + AW'(1);
                if (src_inc) src_addr <= src_addr + step;
                if (dst_inc) dst_addr <= dst_addr + step;
            end
        end
    end

    // Bus pins float whenever this master does not own the bus
    assign MAB      = owner ? ((state == WRITE) ? dst_addr : src_addr) : {AW{1'bz}};
    assign MDBwrite = owner ? data : {AW{1'bz}};
    assign MW       = owner ? (state == WRITE) : 1'bz;
    assign BW       = owner ? mode : 1'bz;

endmodule

// File: tb/tb_dma_block_mover.sv
// Scoreboard bench for dma_block_mover: byte-addressed memory model, expected
// bus writes queued by the stimulus and popped by a negedge monitor.
module tb_dma_block_mover;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bw;
    } wr_t;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        start;
    logic        start1;
    logic        abort;
    logic [15:0] SRC;
    logic [15:0] DST;
    logic [15:0] SZ;
    logic        BWmode;
    logic        SRCINC;
    logic        DSTINC;
    logic        busGrant;
    logic        busGrant1;
    logic [15:0] MDBread;
    logic [15:0] MDBread1;

    logic        busReq, busy, done;
    logic [15:0] remaining;
    wire  [15:0] MAB, MDBwrite;
    wire         MW, BW;

    logic        busReq1, busy1, done1;
    logic [15:0] remaining1;
    wire  [15:0] MAB1, MDBwrite1;
    wire         MW1, BW1;

    logic [7:0]  mem [0:65535];
    logic [15:0] a_even;
    wr_t         exp_q[$];
    wr_t         exp1_q[$];
    wr_t         e0, e1;
    int          checks = 0;
    int          errors = 0;
    logic        seen_req;

    always #5 MCLK = ~MCLK;

    dma_block_mover #(.BURST_LEN(0)) dut (
        .MCLK(MCLK), .reset(reset), .start(start), .abort(abort),
        .SRC(SRC), .DST(DST), .SZ(SZ), .BWmode(BWmode),
        .SRCINC(SRCINC), .DSTINC(DSTINC), .busGrant(busGrant), .MDBread(MDBread),
        .busReq(busReq), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
        .busy(busy), .done(done), .remaining(remaining)
    );

    dma_block_mover #(.BURST_LEN(2)) dut1 (
        .MCLK(MCLK), .reset(reset), .start(start1), .abort(abort),
        .SRC(SRC), .DST(DST), .SZ(SZ), .BWmode(BWmode),
        .SRCINC(SRCINC), .DSTINC(DSTINC), .busGrant(busGrant1), .MDBread(MDBread1),
        .busReq(busReq1), .MAB(MAB1), .MDBwrite(MDBwrite1), .MW(MW1), .BW(BW1),
        .busy(busy1), .done(done1), .remaining(remaining1)
    );

    // Memory slave: byte reads on the low lane, word reads ignore address LSB
    assign a_even   = {MAB[15:1], 1'b0};
    assign MDBread  = (BW === 1'b1) ? {8'h00, mem[MAB]} : {mem[a_even | 16'h0001], mem[a_even]};
    assign MDBread1 = MAB1 ^ 16'h5A5A;

    always @(posedge MCLK) begin
        if (!reset && busGrant && MW === 1'b1) begin
            if (BW === 1'b1) begin
                mem[MAB] = MDBwrite[7:0];
            end else begin
                mem[a_even]              = MDBwrite[7:0];
                mem[a_even | 16'h0001]   = MDBwrite[15:8];
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge MCLK) begin
        if (busReq) seen_req = 1'b1;
        if (!reset && busGrant && MW === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", MAB, MDBwrite);
            end else begin
                e0 = exp_q.pop_front();
                check("wr_addr", 32'(MAB), 32'(e0.addr));
                check("wr_data", 32'(MDBwrite), 32'(e0.data));
                check("wr_bw", 32'(BW), 32'(e0.bw));
            end
        end
        if (!reset && busGrant1 && MW1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write1: addr %h data %h with no write expected", MAB1, MDBwrite1);
            end else begin
                e1 = exp1_q.pop_front();
                check("wr1_addr", 32'(MAB1), 32'(e1.addr));
                check("wr1_data", 32'(MDBwrite1), 32'(e1.data));
            end
        end
    end

    task automatic push(logic [15:0] a, logic [15:0] d, logic b);
        wr_t w;
        w.addr = a; w.data = d; w.bw = b;
        exp_q.push_back(w);
    endtask

    task automatic poke(logic [15:0] a, logic [15:0] v);
        mem[a] = v[7:0];
        mem[a | 16'h0001] = v[15:8];
    endtask

    function automatic logic [15:0] peek(logic [15:0] a);
        return {mem[a | 16'h0001], mem[a]};
    endfunction

    task automatic cfg(logic [15:0] s, logic [15:0] d, logic [15:0] n, logic bw, logic si, logic di);
        SRC = s; DST = d; SZ = n; BWmode = bw; SRCINC = si; DSTINC = di;
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycles counted from the start cycle to the cycle where done is seen
    task automatic run_block(output int cyc);
        kick();
        cyc = 0;
        while (cyc < 100) begin
            @(negedge MCLK);
            cyc++;
            if (done) break;
            tick();
        end
    endtask

    initial begin
        int cyc;
        logic [16:0] req_trace;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        busGrant = 1'b1; busGrant1 = 1'b1; seen_req = 1'b0;
        cfg(16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        @(negedge MCLK);
        check("rst_busReq", 32'(busReq), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_mw_driven", 32'(MW === 1'b1), 0);
        tick();
        reset = 1'b0;
        tick();

        // Word copy with both addresses incrementing
        poke(16'h2000, 16'h1111); poke(16'h2002, 16'h2222); poke(16'h2004, 16'h3333);
        cfg(16'h2000, 16'h2400, 16'd3, 1'b0, 1'b1, 1'b1);
        push(16'h2400, 16'h1111, 1'b0); push(16'h2402, 16'h2222, 1'b0); push(16'h2404, 16'h3333, 1'b0);
        run_block(cyc);
        check("word_latency", 32'(cyc), 9);
        check("word_remaining", 32'(remaining), 0);
        check("word_mem0", 32'(peek(16'h2400)), 32'h1111);
        check("word_mem1", 32'(peek(16'h2402)), 32'h2222);
        check("word_mem2", 32'(peek(16'h2404)), 32'h3333);
        tick();

        // Byte copy to a fixed destination
        mem[16'h2001] = 8'hAB; mem[16'h2002] = 8'hCD;
        cfg(16'h2001, 16'h3000, 16'd2, 1'b1, 1'b1, 1'b0);
        push(16'h3000, 16'h00AB, 1'b1); push(16'h3000, 16'h00CD, 1'b1);
        run_block(cyc);
        check("byte_latency", 32'(cyc), 7);
        check("byte_mem", 32'(mem[16'h3000]), 32'hCD);
        check("byte_neighbour", 32'(mem[16'h3001]), 32'h00);
        tick();

        // Zero-length block completes without touching the bus
        seen_req = 1'b0;
        cfg(16'h2000, 16'h3100, 16'd0, 1'b0, 1'b1, 1'b1);
        run_block(cyc);
        check("zero_latency", 32'(cyc), 2);
        check("zero_no_req", 32'(seen_req), 0);
        tick();

        // Grant withdrawn for three cycles during the second WRITE
        poke(16'h2100, 16'hA1A1); poke(16'h2102, 16'hB2B2); poke(16'h2104, 16'hC3C3);
        cfg(16'h2100, 16'h2500, 16'd3, 1'b0, 1'b1, 1'b1);
        push(16'h2500, 16'hA1A1, 1'b0); push(16'h2502, 16'hB2B2, 1'b0); push(16'h2504, 16'hC3C3, 1'b0);
        fork
            run_block(cyc);
            begin
                repeat (5) @(posedge MCLK);
                #1 busGrant = 1'b0;
                repeat (3) begin
                    @(negedge MCLK);
                    check("gap_mw_driven", 32'(MW === 1'b1), 0);
                    check("gap_busReq", 32'(busReq), 1);
                    check("gap_remaining", 32'(remaining), 2);
                end
                @(posedge MCLK);
                #1 busGrant = 1'b1;
            end
        join
        check("gap_latency", 32'(cyc), 12);
        check("gap_mem1", 32'(peek(16'h2502)), 32'hB2B2);
        check("gap_mem2", 32'(peek(16'h2504)), 32'hC3C3);
        tick();

        // Source address wraps from 0xFFFE to 0x0000
        poke(16'hFFFE, 16'h4444); poke(16'h0000, 16'h5555);
        cfg(16'hFFFE, 16'h2800, 16'd2, 1'b0, 1'b1, 1'b0);
        push(16'h2800, 16'h4444, 1'b0); push(16'h2800, 16'h5555, 1'b0);
        run_block(cyc);
        check("wrap_latency", 32'(cyc), 7);
        check("wrap_mem", 32'(peek(16'h2800)), 32'h5555);
        tick();

        // Abort during the second element's READ
        cfg(16'h2100, 16'h2600, 16'd3, 1'b0, 1'b1, 1'b1);
        push(16'h2600, 16'hA1A1, 1'b0);
        kick();
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge MCLK);
        check("abort_busy", 32'(busy), 0);
        check("abort_busReq", 32'(busReq), 0);
        check("abort_done", 32'(done), 0);
        check("abort_remaining", 32'(remaining), 2);
        check("abort_mw_driven", 32'(MW === 1'b1), 0);
        tick();
        @(negedge MCLK);
        check("abort_no_done", 32'(done), 0);
        check("abort_mem_untouched", 32'(peek(16'h2602)), 0);
        tick();

        // Reset asserted in the middle of the first WRITE
        cfg(16'h2100, 16'h2700, 16'd3, 1'b0, 1'b1, 1'b1);
        kick();
        tick(); tick();
        #1;
        check("rstw_in_write", 32'(MW === 1'b1), 1);
        reset = 1'b1;
        #1;
        check("rstw_busy", 32'(busy), 0);
        check("rstw_busReq", 32'(busReq), 0);
        check("rstw_done", 32'(done), 0);
        check("rstw_remaining", 32'(remaining), 0);
        check("rstw_mw_driven", 32'(MW === 1'b1), 0);
        tick();
        reset = 1'b0;
        tick();
        check("rstw_mem", 32'(peek(16'h2700)), 0);

        // Burst of two: busReq drops one cycle after elements 2 and 4
        cfg(16'h1000, 16'h1800, 16'd5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wr_t w;
            w.addr = 16'h1800 + 16'(2 * i);
            w.data = (16'h1000 + 16'(2 * i)) ^ 16'h5A5A;
            w.bw   = 1'b0;
            exp1_q.push_back(w);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge MCLK);
            req_trace[16 - i] = busReq1;
            if (i == 16) check("burst_done", 32'(done1), 1);
            tick();
        end
        check("burst_req_trace", 32'(req_trace), 32'(17'b11111011111011100));
        check("burst_remaining", 32'(remaining1), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        check("queue1_drained", 32'(exp1_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
